// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: zero-latency, combinational controls from state+inputs.
// Optional perf counters (perf_stall_cnt/perf_flush_cnt) are built only with PIPE_CTRL_PERF_EN defined.
module pipeline_ctrl #(
  parameter int XCPT_CYCLES = 2,
  parameter int PERF_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_to_use_hazard,
  input  logic             branch_taken_exe,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  input  logic             exc_req_mem,
  output logic             stall_fetch,
  output logic             stall_dec,
  output logic             stall_exe,
  output logic             stall_mem,
  output logic             kill_fetch,
  output logic             kill_dec,
  output logic             kill_exe,
  output logic             kill_mem,
  output logic             kill_wb,
  output logic             redirect_branch,
  output logic             redirect_xcpt,
  output logic [1:0]       ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    XCPT  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(XCPT_CYCLES - 1);

  if (XCPT_CYCLES < 1 || XCPT_CYCLES > 15) begin : g_bad_xcpt_cycles
    $error("pipeline_ctrl: XCPT_CYCLES must be 1..15");
  end
  if (PERF_W < 1) begin : g_bad_perf_w
    $error("pipeline_ctrl: PERF_W must be >= 1");
  end

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [3:0] stall_raw;   // {fetch, dec, exe, mem}
  logic [4:0] kill_raw;    // {fetch, dec, exe, mem, wb}
  logic       rb_raw, rx_raw;
  logic [3:0] stall_q;
  logic [4:0] kill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN, DMISS: begin
        if (exc_req_mem) begin
          state_nxt = XCPT;
          cnt_nxt   = CNT_INIT;
        end else if (dcache_miss) begin
          state_nxt = DMISS;
        end else begin
          state_nxt = RUN;
        end
      end
      XCPT: begin
        if (cnt == 4'd0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    stall_raw = 4'b0000;
    kill_raw  = 5'b00000;
    rb_raw    = 1'b0;
    rx_raw    = 1'b0;
    if (state == XCPT) begin
      kill_raw = 5'b01000;
    end else if (exc_req_mem) begin
      kill_raw = 5'b01111;
      rx_raw   = 1'b1;
    end else if (dcache_miss) begin
      stall_raw = 4'b1111;
      kill_raw  = 5'b00001;
    end else if (branch_taken_exe) begin
      kill_raw = 5'b01100;
      rb_raw   = 1'b1;
    end else if (load_to_use_hazard) begin
      stall_raw = 4'b1100;
      kill_raw  = 5'b00100;
    end else if (icache_miss) begin
      stall_raw = 4'b1000;
      kill_raw  = 5'b01000;
    end
  end

  // Reset forces bubbles everywhere; otherwise a kill always overrides a stall on the same stage.
  always_comb begin
    if (rst) begin
      stall_q = 4'b0000;
      kill_q  = 5'b11111;
    end else begin
      stall_q = stall_raw & ~kill_raw[4:1];
      kill_q  = kill_raw;
    end
  end

  assign {stall_fetch, stall_dec, stall_exe, stall_mem}        = stall_q;
  assign {kill_fetch, kill_dec, kill_exe, kill_mem, kill_wb}   = kill_q;
  assign redirect_branch = rb_raw & ~rst;
  assign redirect_xcpt   = rx_raw & ~rst;
  // DMISS ends in the very cycle dcache_miss drops, so the reported state does too.
  assign ctrl_state = (state == DMISS && !dcache_miss) ? RUN : state;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_fetch) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (redirect_branch || redirect_xcpt) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl (XCPT_CYCLES = 2).
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic ltu, br, imiss, dmiss, exc;
  logic stall_fetch, stall_dec, stall_exe, stall_mem;
  logic kill_fetch, kill_dec, kill_exe, kill_mem, kill_wb;
  logic redirect_branch, redirect_xcpt;
  logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [3:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .XCPT_CYCLES(2),
    .PERF_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_to_use_hazard(ltu),
    .branch_taken_exe(br),
    .icache_miss(imiss),
    .dcache_miss(dmiss),
    .exc_req_mem(exc),
    .stall_fetch(stall_fetch),
    .stall_dec(stall_dec),
    .stall_exe(stall_exe),
    .stall_mem(stall_mem),
    .kill_fetch(kill_fetch),
    .kill_dec(kill_dec),
    .kill_exe(kill_exe),
    .kill_mem(kill_mem),
    .kill_wb(kill_wb),
    .redirect_branch(redirect_branch),
    .redirect_xcpt(redirect_xcpt),
    .ctrl_state(ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // Output vector layout: {stall f,d,e,m}_{kill f,d,e,m,wb}_{redir br,xcpt}_{state}
  logic [12:0] outs;
  assign outs = {stall_fetch, stall_dec, stall_exe, stall_mem,
                 kill_fetch, kill_dec, kill_exe, kill_mem, kill_wb,
                 redirect_branch, redirect_xcpt, ctrl_state};

  localparam logic [12:0] E_IDLE  = 13'b0000_00000_00_00;
  localparam logic [12:0] E_RST   = 13'b0000_11111_00_00;
  localparam logic [12:0] E_LTU   = 13'b1100_00100_00_00;
  localparam logic [12:0] E_BR    = 13'b0000_01100_10_00;
  localparam logic [12:0] E_IMISS = 13'b1000_01000_00_00;
  localparam logic [12:0] E_DM0   = 13'b1111_00001_00_00;
  localparam logic [12:0] E_DM1   = 13'b1111_00001_00_01;
  localparam logic [12:0] E_EXC   = 13'b0000_01111_01_00;
  localparam logic [12:0] E_EXCD  = 13'b0000_01111_01_01;
  localparam logic [12:0] E_XCPT  = 13'b0000_01000_00_10;

  // Input vector layout: {ltu, br, imiss, dmiss, exc}
  typedef struct {
    string       name;
    logic [4:0]  in;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled mid-cycle.
  task automatic step(input string nm, input logic [4:0] in, input logic [12:0] exp);
    {ltu, br, imiss, dmiss, exc} = in;
    #4;
    check(nm, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {ltu, br, imiss, dmiss, exc} = 5'b0;
    #2;
    check("reset_outputs", outs, E_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;

    vecs.push_back('{"idle",            5'b00000, E_IDLE});
    vecs.push_back('{"ltu",             5'b10000, E_LTU});
    vecs.push_back('{"ltu_one_cycle",   5'b00000, E_IDLE});
    vecs.push_back('{"br_ltu_imiss",    5'b11100, E_BR});
    vecs.push_back('{"br_only",         5'b01000, E_BR});
    vecs.push_back('{"imiss",           5'b00100, E_IMISS});
    vecs.push_back('{"ltu_over_imiss",  5'b10100, E_LTU});
    vecs.push_back('{"dmiss_over_all",  5'b11110, E_DM0});
    vecs.push_back('{"dmiss_exit_idle", 5'b00000, E_IDLE});
    vecs.push_back('{"exc_over_dmiss",  5'b01011, E_EXC});
    vecs.push_back('{"xcpt_ignore_br",  5'b01000, E_XCPT});
    vecs.push_back('{"xcpt_ignore_exc", 5'b00001, E_XCPT});
    vecs.push_back('{"xcpt_done",       5'b00000, E_IDLE});
    vecs.push_back('{"dmiss_then_br",   5'b00010, E_DM0});
    vecs.push_back('{"dmiss_exit_br",   5'b01000, E_BR});
    foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Data miss held 5 cycles, then released.
    step("dmiss_c1", 5'b00010, E_DM0);
    for (int c = 2; c <= 5; c++) step($sformatf("dmiss_c%0d", c), 5'b00010, E_DM1);
    step("dmiss_c6_run", 5'b00000, E_IDLE);

    // Exception in cycle 3 of a data miss; the miss stays asserted but is ignored.
    step("xd_c1", 5'b00010, E_DM0);
    step("xd_c2", 5'b00010, E_DM1);
    step("xd_exc", 5'b00011, E_EXCD);
    step("xd_drain1", 5'b00010, E_XCPT);
    step("xd_drain2", 5'b00010, E_XCPT);
    step("xd_run", 5'b00000, E_IDLE);

    // Reset asserted mid-XCPT, away from any clock edge.
    step("rx_exc", 5'b00001, E_EXC);
    {ltu, br, imiss, dmiss, exc} = 5'b00001;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_xcpt", outs, E_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst_xcpt_release", 5'b00000, E_IDLE);

    // Reset asserted mid-DMISS.
    step("rd_c1", 5'b00010, E_DM0);
    {ltu, br, imiss, dmiss, exc} = 5'b00010;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_dmiss", outs, E_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst_dmiss_release", 5'b00010, E_DM0);
    step("rst_dmiss_idle", 5'b00000, E_IDLE);

`ifdef PIPE_CTRL_PERF_EN
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 17; k++) step("perf_ltu", 5'b10000, E_LTU);
    for (int k = 0; k < 3; k++) step("perf_br", 5'b01000, E_BR);
    #4;
    check("perf_stall_wrap", {9'b0, perf_stall_cnt}, 13'd1);
    check("perf_flush_cnt", {9'b0, perf_flush_cnt}, 13'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, required under 50000ns");
    $fatal(1);
  end

endmodule
